// File: rtl/free_list_mw_pkg.sv
// Shared register-file types for the rename stage: architectural/physical
// register counts and the physical register index type.
package rv32i_types;
    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int PREG_W    = $clog2(PHYS_REGS);

    typedef logic [PREG_W-1:0] preg_t;
endpackage

// File: rtl/free_list_mw_if.sv
// Allocation / return / checkpoint port bundle of the multi-lane free list.
interface free_list_mw_if
    import rv32i_types::*;
#(
    parameter int WIDTH = 2,
    parameter int CKPTS = 4,
    parameter int DEPTH = PHYS_REGS - ARCH_REGS
);
    localparam int CNT_W   = $clog2(WIDTH + 1);
    localparam int CKPT_W  = (CKPTS > 1) ? $clog2(CKPTS) : 1;
    localparam int COUNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]   deq_cnt_in;
    logic               deq_ok_out;
    preg_t [WIDTH-1:0]  rdata_out;
    logic [WIDTH-1:0]   enq_valid_in;
    preg_t [WIDTH-1:0]  enq_data_in;
    logic               ckpt_save_in;
    logic [CKPT_W-1:0]  ckpt_id_in;
    logic               restore_in;
    logic [CKPT_W-1:0]  restore_id_in;
    logic               flush_in;
    logic [COUNT_W-1:0] count_out;
    logic               empty_out;

    modport slave (
        input  deq_cnt_in, enq_valid_in, enq_data_in, ckpt_save_in, ckpt_id_in,
               restore_in, restore_id_in, flush_in,
        output deq_ok_out, rdata_out, count_out, empty_out
    );

    modport master (
        output deq_cnt_in, enq_valid_in, enq_data_in, ckpt_save_in, ckpt_id_in,
               restore_in, restore_id_in, flush_in,
        input  deq_ok_out, rdata_out, count_out, empty_out
    );
endinterface

// File: rtl/free_list_mw_ptr_add.sv
// Circular-buffer pointer adder: index wraps at DEPTH (any value, not only
// powers of two) and the top bit toggles on each wrap.
module fl_ptr_add #(
    parameter int DEPTH = 32,
    parameter int IDX_W = 5,
    parameter int INC_W = 2
) (
    input  logic [IDX_W:0]   i_ptr,
    input  logic [INC_W-1:0] i_inc,
    output logic [IDX_W:0]   o_sum
);
    logic [IDX_W:0] w_sum;
    logic [IDX_W:0] w_wrapped;

    // i_inc never exceeds DEPTH, so at most one wrap is possible.
    always_comb begin
        w_sum     = {1'b0, i_ptr[IDX_W-1:0]} + (IDX_W+1)'(i_inc);
        w_wrapped = w_sum - (IDX_W+1)'(DEPTH);
        if (w_sum >= (IDX_W+1)'(DEPTH)) begin
            o_sum = {~i_ptr[IDX_W], w_wrapped[IDX_W-1:0]};
        end else begin
            o_sum = {i_ptr[IDX_W], w_sum[IDX_W-1:0]};
        end
    end
endmodule

// File: rtl/free_list_mw.sv
// Multi-lane physical register free list with branch checkpoints of the head
// pointer, mispredict restore and global flush.
module free_list_mw
    import rv32i_types::*;
#(
    parameter int WIDTH = 2,
    parameter int CKPTS = 4,
    parameter int DEPTH = PHYS_REGS - ARCH_REGS
) (
    input  logic           clk,
    input  logic           rst,
    free_list_mw_if.slave  fl
);
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(WIDTH + 1);
    localparam int COUNT_W = $clog2(DEPTH + 1);

    preg_t              r_mem [DEPTH];
    logic [IDX_W:0]     r_head;
    logic [IDX_W:0]     r_tail;
    logic [IDX_W:0]     r_ckpt [CKPTS];
    logic [COUNT_W-1:0] r_count;
    logic               r_empty;

    logic                     w_deq_ok;
    logic [CNT_W-1:0]         w_deq_inc;
    logic [IDX_W:0]           w_head_adv;
    logic [IDX_W:0]           w_head_next;
    logic [IDX_W:0]           w_tail_next;
    logic [COUNT_W-1:0]       w_count_next;
    logic [WIDTH:0][CNT_W-1:0] w_prefix;
    logic [IDX_W:0]           w_raddr [WIDTH];
    logic [IDX_W:0]           w_waddr [WIDTH];

    function automatic logic [COUNT_W-1:0] f_count(logic [IDX_W:0] t, logic [IDX_W:0] h);
        logic [IDX_W+1:0] d;
        if (t[IDX_W] == h[IDX_W]) begin
            d = {2'b00, t[IDX_W-1:0]} - {2'b00, h[IDX_W-1:0]};
        end else begin
            d = (IDX_W+2)'(DEPTH) + {2'b00, t[IDX_W-1:0]} - {2'b00, h[IDX_W-1:0]};
        end
        return COUNT_W'(d);
    endfunction

    // Only the registered count is trusted, so same-cycle returns cannot be granted.
    assign w_deq_ok  = !rst && (COUNT_W'(fl.deq_cnt_in) <= r_count)
                       && !fl.flush_in && !fl.restore_in;
    assign w_deq_inc = w_deq_ok ? fl.deq_cnt_in : '0;

    assign w_prefix[0] = '0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            assign w_prefix[gi+1] = w_prefix[gi] + CNT_W'(fl.enq_valid_in[gi]);

            fl_ptr_add #(.DEPTH(DEPTH), .IDX_W(IDX_W), .INC_W(CNT_W)) u_raddr (
                .i_ptr (r_head),
                .i_inc (CNT_W'(gi)),
                .o_sum (w_raddr[gi])
            );

            // Valid lanes are packed densely starting at the current tail.
            fl_ptr_add #(.DEPTH(DEPTH), .IDX_W(IDX_W), .INC_W(CNT_W)) u_waddr (
                .i_ptr (r_tail),
                .i_inc (w_prefix[gi]),
                .o_sum (w_waddr[gi])
            );
        end
    endgenerate

    fl_ptr_add #(.DEPTH(DEPTH), .IDX_W(IDX_W), .INC_W(CNT_W)) u_head_add (
        .i_ptr (r_head),
        .i_inc (w_deq_inc),
        .o_sum (w_head_adv)
    );

    fl_ptr_add #(.DEPTH(DEPTH), .IDX_W(IDX_W), .INC_W(CNT_W)) u_tail_add (
        .i_ptr (r_tail),
        .i_inc (w_prefix[WIDTH]),
        .o_sum (w_tail_next)
    );

    // Flush: head sits exactly DEPTH behind the new tail, i.e. opposite wrap bit.
    always_comb begin
        w_head_next = w_head_adv;
        if (fl.flush_in) begin
            w_head_next = {~w_tail_next[IDX_W], w_tail_next[IDX_W-1:0]};
        end else if (fl.restore_in) begin
            w_head_next = r_ckpt[fl.restore_id_in];
        end
        w_count_next = f_count(w_tail_next, w_head_next);
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            fl.rdata_out[i] = r_mem[w_raddr[i][IDX_W-1:0]];
        end
    end

    assign fl.deq_ok_out = w_deq_ok;
    assign fl.count_out  = r_count;
    assign fl.empty_out  = r_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= preg_t'(ARCH_REGS + i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (fl.enq_valid_in[i]) begin
                    r_mem[w_waddr[i][IDX_W-1:0]] <= fl.enq_data_in[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= {1'b1, {IDX_W{1'b0}}};
            r_count <= COUNT_W'(DEPTH);
            r_empty <= 1'b0;
            for (int i = 0; i < CKPTS; i++) begin
                r_ckpt[i] <= '0;
            end
        end else begin
            r_head  <= w_head_next;
            r_tail  <= w_tail_next;
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            // The snapshot follows this cycle's grant so the branch keeps its own destination.
            if (fl.ckpt_save_in && !fl.flush_in && !fl.restore_in) begin
                r_ckpt[fl.ckpt_id_in] <= w_head_adv;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !fl.flush_in && !fl.restore_in) begin
            assert (int'(r_count) - int'(w_deq_inc) + int'(w_prefix[WIDTH]) <= DEPTH);
        end
    end
endmodule

// File: tb/tb_free_list_mw.sv
// Directed bench for free_list_mw: grants, compaction, checkpoints, flush, reset.
module tb_free_list_mw;
    import rv32i_types::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    free_list_mw_if #(.WIDTH(2), .CKPTS(4), .DEPTH(32)) ifc ();

    free_list_mw #(.WIDTH(2), .CKPTS(4), .DEPTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .fl  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifc.deq_cnt_in    = '0;
        ifc.enq_valid_in  = '0;
        ifc.enq_data_in   = '0;
        ifc.ckpt_save_in  = 1'b0;
        ifc.ckpt_id_in    = '0;
        ifc.restore_in    = 1'b0;
        ifc.restore_id_in = '0;
        ifc.flush_in      = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        idle();
        tick();
        tick();

        $display("step: dequeue request during reset");
        ifc.deq_cnt_in = 2;
        #1;
        chk("ok_in_reset", 32'(ifc.deq_ok_out), 0);
        rst = 1'b0;
        ifc.deq_cnt_in = 0;
        #1;
        chk("reset_count", 32'(ifc.count_out), 32);
        chk("reset_empty", 32'(ifc.empty_out), 0);
        chk("reset_rd0", 32'(ifc.rdata_out[0]), 32);
        chk("reset_rd1", 32'(ifc.rdata_out[1]), 33);

        $display("step: two back-to-back dual grants");
        ifc.deq_cnt_in = 2;
        #1;
        chk("g1_ok", 32'(ifc.deq_ok_out), 1);
        chk("g1_rd0", 32'(ifc.rdata_out[0]), 32);
        chk("g1_rd1", 32'(ifc.rdata_out[1]), 33);
        tick();
        chk("g1_count", 32'(ifc.count_out), 30);
        #1;
        chk("g2_rd0", 32'(ifc.rdata_out[0]), 34);
        chk("g2_rd1", 32'(ifc.rdata_out[1]), 35);
        tick();
        chk("g2_count", 32'(ifc.count_out), 28);

        $display("step: enqueue on lane 1 only, value 50");
        idle();
        ifc.enq_valid_in   = 2'b10;
        ifc.enq_data_in[0] = 7;
        ifc.enq_data_in[1] = 50;
        tick();
        chk("enq_count", 32'(ifc.count_out), 29);
        idle();

        $display("step: drain 28 original entries");
        for (int k = 0; k < 14; k++) begin
            ifc.deq_cnt_in = 2;
            #1;
            chk("drain_rd0", 32'(ifc.rdata_out[0]), 32'(36 + 2 * k));
            chk("drain_rd1", 32'(ifc.rdata_out[1]), 32'(37 + 2 * k));
            tick();
            chk("drain_count", 32'(ifc.count_out), 32'(27 - 2 * k));
        end

        $display("step: request 2 with one free, same-cycle enqueue of 40");
        ifc.deq_cnt_in     = 2;
        ifc.enq_valid_in   = 2'b01;
        ifc.enq_data_in[0] = 40;
        #1;
        chk("short_ok", 32'(ifc.deq_ok_out), 0);
        chk("short_rd0", 32'(ifc.rdata_out[0]), 50);
        tick();
        chk("short_count", 32'(ifc.count_out), 2);
        idle();
        ifc.deq_cnt_in = 2;
        #1;
        chk("after_ok", 32'(ifc.deq_ok_out), 1);
        chk("after_rd0", 32'(ifc.rdata_out[0]), 50);
        chk("after_rd1", 32'(ifc.rdata_out[1]), 40);
        tick();
        chk("drained_count", 32'(ifc.count_out), 0);
        chk("drained_empty", 32'(ifc.empty_out), 1);

        $display("step: enqueue 3 into empty list, then flush with enqueue of 2");
        idle();
        ifc.enq_valid_in   = 2'b11;
        ifc.enq_data_in[0] = 41;
        ifc.enq_data_in[1] = 42;
        tick();
        ifc.enq_valid_in   = 2'b01;
        ifc.enq_data_in[0] = 43;
        tick();
        chk("three_count", 32'(ifc.count_out), 3);
        ifc.enq_valid_in   = 2'b11;
        ifc.enq_data_in[0] = 44;
        ifc.enq_data_in[1] = 45;
        ifc.flush_in       = 1'b1;
        ifc.deq_cnt_in     = 2;
        #1;
        chk("flush_ok", 32'(ifc.deq_ok_out), 0);
        tick();
        idle();
        #1;
        chk("flush_count", 32'(ifc.count_out), 32);
        chk("flush_empty", 32'(ifc.empty_out), 0);
        chk("flush_rd0", 32'(ifc.rdata_out[0]), 39);
        chk("flush_rd1", 32'(ifc.rdata_out[1]), 40);

        $display("step: save slot 1 with grant, dequeue 4, restore 1");
        do_reset();
        ifc.deq_cnt_in   = 2;
        ifc.ckpt_save_in = 1'b1;
        ifc.ckpt_id_in   = 1;
        tick();
        ifc.ckpt_save_in = 1'b0;
        #1;
        chk("ck_rd0", 32'(ifc.rdata_out[0]), 34);
        tick();
        tick();
        chk("ck_count", 32'(ifc.count_out), 26);
        ifc.restore_in    = 1'b1;
        ifc.restore_id_in = 1;
        ifc.ckpt_save_in  = 1'b1;
        ifc.ckpt_id_in    = 2;
        #1;
        chk("restore_ok", 32'(ifc.deq_ok_out), 0);
        tick();
        idle();
        chk("restore_count", 32'(ifc.count_out), 30);
        ifc.deq_cnt_in = 2;
        #1;
        chk("restore_gok", 32'(ifc.deq_ok_out), 1);
        chk("restore_rd0", 32'(ifc.rdata_out[0]), 34);
        chk("restore_rd1", 32'(ifc.rdata_out[1]), 35);
        tick();
        chk("restore_gcount", 32'(ifc.count_out), 28);

        $display("step: restore slot 2, whose save was masked by a restore");
        idle();
        ifc.restore_in    = 1'b1;
        ifc.restore_id_in = 2;
        tick();
        idle();
        chk("slot2_count", 32'(ifc.count_out), 32);
        chk("slot2_rd0", 32'(ifc.rdata_out[0]), 32);

        $display("step: flush and restore together");
        ifc.deq_cnt_in = 2;
        tick();
        chk("pre_fr_count", 32'(ifc.count_out), 30);
        idle();
        ifc.flush_in      = 1'b1;
        ifc.restore_in    = 1'b1;
        ifc.restore_id_in = 1;
        tick();
        idle();
        chk("fr_count", 32'(ifc.count_out), 32);
        chk("fr_rd0", 32'(ifc.rdata_out[0]), 32);

        $display("step: reset arriving mid-restore");
        ifc.deq_cnt_in = 2;
        tick();
        tick();
        chk("pre_rst_count", 32'(ifc.count_out), 28);
        ifc.restore_in     = 1'b1;
        ifc.restore_id_in  = 1;
        ifc.enq_valid_in   = 2'b01;
        ifc.enq_data_in[0] = 60;
        rst = 1'b1;
        #1;
        chk("rst_ok", 32'(ifc.deq_ok_out), 0);
        tick();
        rst = 1'b0;
        idle();
        chk("rst_count", 32'(ifc.count_out), 32);
        chk("rst_empty", 32'(ifc.empty_out), 0);
        chk("rst_rd0", 32'(ifc.rdata_out[0]), 32);
        ifc.restore_in    = 1'b1;
        ifc.restore_id_in = 1;
        tick();
        idle();
        chk("rst_ckpt_count", 32'(ifc.count_out), 32);
        chk("rst_ckpt_rd0", 32'(ifc.rdata_out[0]), 32);
        chk("rst_ckpt_rd1", 32'(ifc.rdata_out[1]), 33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
